// File: rtl/serial_addsub.sv
// Bit-serial add/subtract unit. One full-adder slice and a registered carry
// process one bit per clock, LSB first.
//
// Operands arrive over an in_valid/in_ready handshake. The result arrives over
// an out_valid/out_ready handshake, together with a carry-out and a signed
// overflow flag.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand transfer request
//   in_ready   high in IDLE; operands can be accepted
//   a, b       operands (WIDTH bits)
//   cin        carry-in (add) / borrow-in (subtract)
//   sub        0: a+b+cin, 1: a-b-cin
//   out_valid  high in DONE; result is available
//   out_ready  consumer accepts the result
//   sum        result word; held until the next result completes
//   cout       carry out of MSB; in subtract mode 1 means no borrow
//   ovf        two's-complement overflow
//   busy       high in SHIFT or DONE
module serial_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic s_bit;
  logic c_next;

  // Single full-adder slice on the current LSBs
  assign s_bit  = a_q[0] ^ b_q[0] ^ carry_q;
  assign c_next = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d = a;
          // Subtraction as a + ~b + ~cin: the inverted borrow becomes the carry-in
          b_d     = sub ? ~b : b;
          carry_d = cin ^ sub;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {s_bit, res_q[WIDTH-1:1]};
        carry_d = c_next;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          // carry_q here is the carry into the MSB
          sum_d   = res_d;
          cout_d  = c_next;
          ovf_d   = carry_q ^ c_next;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       sub;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;
  logic       busy;

  int passed = 0;
  int total  = 0;

  serial_addsub #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic       vcin;
    logic       vsub;
    logic [7:0] esum;
    logic       ecout;
    logic       eovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one operation through both handshakes. Result is sampled after the
  // stall, just before release, so holding under backpressure is exercised.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tcin,
                       input logic tsub, input int stall, output logic [7:0] rs,
                       output logic rc, output logic ro, output int lat);
    int n;
    a = ta; b = tb_v; cin = tcin; sub = tsub; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    tick();
    in_valid = 1'b0;
    // Scramble inputs: they must only be sampled on the accepting edge
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    repeat (stall) tick();
    rs = sum; rc = cout; ro = ovf;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
  endtask

  vec_t       vecs[8];
  logic [7:0] rs;
  logic       rc, ro;
  int         lat;

  initial begin
    logic [8:0] r9;
    logic [7:0] ta, tbv;
    logic       tcin, tsub, ec, eo;
    int         n, acc_at;
    logic       seen_ready;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[4] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_outs", {22'd0, sum, cout, ovf}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub, i % 3, rs, rc, ro, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
      check($sformatf("vec%0d_sum", i), 32'(rs), 32'(vecs[i].esum));
      check($sformatf("vec%0d_cout", i), 32'(rc), 32'(vecs[i].ecout));
      check($sformatf("vec%0d_ovf", i), 32'(ro), 32'(vecs[i].eovf));
    end

    // Backpressure with a concurrent request, then back-to-back issue interval
    a = 8'h5A; b = 8'h3C; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    check("bp_accepted", 32'(busy), 32'd1);
    a = 8'h11; b = 8'h22;
    wait_valid(lat);
    check("bp_latency", 32'(lat), 32'd8);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_hold%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("bp_hold%0d_in_ready", i), 32'(in_ready), 32'd0);
      check($sformatf("bp_hold%0d_res", i), {22'd0, sum, cout, ovf}, {22'd0, 8'h96, 1'b0, 1'b1});
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_retain", {22'd0, sum, cout, ovf}, {22'd0, 8'h96, 1'b0, 1'b1});
    tick();
    check("bp_next_accept", 32'(in_ready), 32'd0);
    a = 8'h05; b = 8'h03; cin = 1'b0; sub = 1'b1;
    // in_valid and out_ready stay high: measure edges to the next accept
    acc_at = -1; seen_ready = 1'b0;
    for (n = 1; n <= 20 && acc_at < 0; n++) begin
      tick();
      if (out_valid) check("b2b_res", {22'd0, sum, cout, ovf}, {22'd0, 8'h33, 1'b0, 1'b0});
      if (in_ready) seen_ready = 1'b1;
      else if (seen_ready) acc_at = n;
    end
    check("b2b_interval", 32'(acc_at), 32'd10);
    in_valid = 1'b0; out_ready = 1'b0;
    wait_valid(lat);
    check("b2b_sub_res", {22'd0, sum, cout, ovf}, {22'd0, 8'h02, 1'b1, 1'b0});
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Asynchronous reset in the middle of SHIFT
    a = 8'hFF; b = 8'hFF; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_outs", {22'd0, sum, cout, ovf}, 32'd0);
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    do_op(8'h01, 8'h01, 1'b0, 1'b0, 0, rs, rc, ro, lat);
    check("arst_after_lat", 32'(lat), 32'd8);
    check("arst_after_res", {22'd0, rs, rc, ro}, {22'd0, 8'h02, 1'b0, 1'b0});

    // Random sweep against an arithmetic reference
    for (int i = 0; i < 1000; i++) begin
      ta = 8'($urandom); tbv = 8'($urandom); tcin = 1'($urandom); tsub = 1'($urandom);
      if (!tsub) begin
        r9 = {1'b0, ta} + {1'b0, tbv} + 9'(tcin);
        ec = r9[8];
        eo = (ta[7] == tbv[7]) && (r9[7] != ta[7]);
      end else begin
        r9 = {1'b0, ta} - {1'b0, tbv} - 9'(tcin);
        ec = ~r9[8];
        eo = (ta[7] != tbv[7]) && (r9[7] != ta[7]);
      end
      do_op(ta, tbv, tcin, tsub, int'($urandom_range(0, 3)), rs, rc, ro, lat);
      check($sformatf("rnd%0d_sum_cout a=%h b=%h cin=%b sub=%b", i, ta, tbv, tcin, tsub),
            {23'd0, rc, rs}, {23'd0, ec, r9[7:0]});
      check($sformatf("rnd%0d_ovf", i), 32'(ro), 32'(eo));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial add/subtract unit built around a single full-adder slice and a registered carry.
- Accepts parallel operands over a valid/ready handshake and processes one bit per clock, LSB first.
- Presents the parallel result with carry-out and signed-overflow flags over a second valid/ready handshake.
- Serves as the sequential, area-minimal counterpart to the combinational full adder, for narrow-datapath blocks where latency is cheaper than gates.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2 to 32.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand transfer request.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (subtract).
- sub  input  1  0 = A+B+cin; 1 = A-B-cin.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result word.
- cout  output  1  carry out of MSB; in subtract mode 1 = no borrow.
- ovf  output  1  two's-complement overflow.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, out_valid=0, sum=0, cout=0, ovf=0, busy=0, internal shift registers, counter and carry cleared.
  - in_ready reflects IDLE (reads 1), but no transfer is possible while rst_n is low.
  - Reset mid-operation aborts the operation; no partial result is ever presented.
- States: IDLE, SHIFT, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE:
  - On the edge where in_valid && in_ready, latch a into the A shift register.
  - Latch b, or ~b if sub=1, into the B shift register.
  - Initialise carry to cin when sub=0, or to ~cin when sub=1.
  - Clear the bit counter and go to SHIFT.
  - a/b/cin/sub are sampled only on that edge.
- SHIFT, one bit per cycle:
  - s = A[0]^B[0]^carry; carry <= majority(A[0],B[0],carry).
  - Shift A and B right; shift s into the result register MSB.
  - When counter==WIDTH-1: capture carry-in of the MSB for ovf, latch final carry into cout, compute ovf = carry_into_msb ^ carry_out, go to DONE.
  - Exactly WIDTH SHIFT cycles per operation.
- Latency: out_valid rises WIDTH clock edges after the accepting edge.
- DONE:
  - sum, cout and ovf are stable and held while out_ready is low (unbounded backpressure).
  - On the edge with out_ready=1, go to IDLE. out_valid drops after that edge; sum/cout/ovf retain their values until the next result.
- Back-to-back operation:
  - in_ready is low in DONE, so no same-cycle result-out/operand-in.
  - Minimum issue interval is WIDTH+2 cycles.
- in_valid asserted while not in IDLE is ignored; the source must hold it until accepted.
- Arithmetic is modulo 2^WIDTH; no saturation.

Test Plan:
- WIDTH=8, sub=0, a=8'h5A, b=8'h3C, cin=0 -> sum=8'h96, cout=0, ovf=1; out_valid high exactly 8 edges after accept.
- sub=0, a=8'hFF, b=8'h01, cin=1 -> sum=8'h01, cout=1, ovf=0.
- sub=1, a=8'h10, b=8'h20, cin=0 -> sum=8'hF0, cout=0 (borrow), ovf=0; then sub=1, a=8'h80, b=8'h01, cin=0 -> sum=8'h7F, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> sum/cout/ovf unchanged, out_valid held, in_ready=0, a concurrent in_valid is not accepted; release -> IDLE next edge, next op accepted one edge later (interval = 10 cycles).
- Pull rst_n low asynchronously after the 3rd SHIFT cycle -> all outputs 0 immediately, state IDLE; after release, op a=8'h01, b=8'h01 -> sum=8'h02, cout=0, ovf=0, with no stale bits from the aborted op.
- Random sweep of 1000 ops (both modes, random out_ready stalls) -> every {cout,sum} matches a+b+cin / a-b-cin reference model; ovf matches the signed check.
